tia_horizontal_sequencer: RTL and testbench

TIA_HORIZONTAL_SEQUENCER -- requirements
Module: tia_horizontal_sequencer

---
 rtl/tia_horizontal_sequencer_if.sv | 25 ++
 rtl/tia_horizontal_sequencer.sv | 93 +++++++++
 tb/tb_tia_horizontal_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/tia_horizontal_sequencer_if.sv
// Horizontal sequencer signal bundle: biphase clocks and CPU strobes in,
// line position and timing outputs back.
interface tia_horizontal_sequencer_if;
   logic       phi1;
   logic       phi2;
   logic       wsync;
   logic       rsync;
   logic       hmove;
   logic [5:0] hcount;
   logic [1:0] hstate;
   logic       hsync;
   logic       hblank;
   logic       rdy;
   logic       phase_err;

   modport master (
      output phi1, phi2, wsync, rsync, hmove,
      input  hcount, hstate, hsync, hblank, rdy, phase_err
   );

   modport slave (
      input  phi1, phi2, wsync, rsync, hmove,
      output hcount, hstate, hsync, hblank, rdy, phase_err
   );
endinterface

// File: rtl/tia_horizontal_sequencer.sv
// Horizontal line sequencer: counts biphase advances across a 57-position
// line, tracks the blank/sync/active phase, and handles the WSYNC halt,
// RSYNC restart and HMOVE extended-blank strobes.
//
// state    | meaning
// ---------+---------------------------------------------
// HB_EARLY | blank before sync (hcount 0..3)
// HS       | horizontal sync pulse (hcount 4..7)
// HB_LATE  | blank after sync (hcount 8..16, or 8..18 with hmove)
// ACTIVE   | visible portion of the line
module tia_horizontal_sequencer (
   input  logic clk,
   input  logic r,
   tia_horizontal_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      HB_EARLY = 2'd0,
      HS       = 2'd1,
      HB_LATE  = 2'd2,
      ACTIVE   = 2'd3
   } hstate_t;

   localparam logic [5:0] LAST_COUNT = 6'd56;

   hstate_t    state_q, state_d;
   logic [5:0] count_q, count_d;
   logic       phi2_q;
   logic       rsync_pend_q, rsync_pend_d;
   logic       hmove_latch_q, hmove_latch_d;
   logic       rdy_q, rdy_d;
   logic       phase_err_q, phase_err_d;
   logic       advance;
   logic       rsync_eff;
   logic       wrap;

   // Register all sequencer state; reset overrides every strobe and advance.
   always_ff @(posedge clk) begin
      if (r) begin
         state_q       <= HB_EARLY;
         count_q       <= 6'd0;
         phi2_q        <= 1'b0;
         rsync_pend_q  <= 1'b0;
         hmove_latch_q <= 1'b0;
         rdy_q         <= 1'b1;
         phase_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         phi2_q        <= bus.phi2;
         rsync_pend_q  <= rsync_pend_d;
         hmove_latch_q <= hmove_latch_d;
         rdy_q         <= rdy_d;
         phase_err_q   <= phase_err_d;
      end
   end

   // Next-state: advance on phi2 rising (blocked by phi1), wrap at end of
   // line or on a pending rsync, phase decode from the new count.
   always_comb begin
      advance       = bus.phi2 & ~phi2_q & ~bus.phi1;
      rsync_eff     = bus.rsync | rsync_pend_q;
      wrap          = advance & (rsync_eff | (count_q >= LAST_COUNT));
      state_d       = state_q;
      count_d       = count_q;
      rsync_pend_d  = rsync_eff;
      if (advance) begin
         rsync_pend_d = 1'b0;
         count_d      = wrap ? 6'd0 : count_q + 6'd1;
         case (count_d)
            6'd0:    state_d = HB_EARLY;
            6'd4:    state_d = HS;
            6'd8:    state_d = HB_LATE;
            6'd17:   if (!hmove_latch_q) state_d = ACTIVE;
            6'd19:   if (hmove_latch_q)  state_d = ACTIVE;
            default: state_d = state_q;
         endcase
      end
      // A new hmove outranks the wrap clear so it applies to the next line.
      hmove_latch_d = bus.hmove ? 1'b1 : (wrap ? 1'b0 : hmove_latch_q);
      // wsync outranks the wrap release so a coincident strobe halts a full line.
      rdy_d         = bus.wsync ? 1'b0 : (wrap ? 1'b1 : rdy_q);
      phase_err_d   = phase_err_q | (bus.phi1 & bus.phi2);
   end

   assign bus.hcount    = count_q;
   assign bus.hstate    = state_q;
   assign bus.hsync     = (state_q == HS);
   assign bus.hblank    = (state_q != ACTIVE);
   assign bus.rdy       = rdy_q;
   assign bus.phase_err = phase_err_q;

endmodule

// File: tb/tb_tia_horizontal_sequencer.sv
// Bench for the horizontal sequencer: positional line model checked every
// cycle, plus hand-computed checkpoints along directed scenarios.
module tb_tia_horizontal_sequencer;

   logic clk = 1'b0;
   logic r   = 1'b0;

   always #5 clk = ~clk;

   tia_horizontal_sequencer_if bus ();

   tia_horizontal_sequencer dut (
      .clk (clk),
      .r   (r),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   int ph = 0;

   // Line model: position on the line plus the few flags that matter.
   int m_count = 0;
   bit m_ext   = 1'b0;
   bit m_latch = 1'b0;
   bit m_halt  = 1'b0;
   bit m_err   = 1'b0;
   bit m_pend  = 1'b0;
   bit m_pphi2 = 1'b0;
   bit model_on = 1'b0;

   bit    pin_valid = 1'b0;
   string pin_name  = "";
   int    pin_hc = 0, pin_hst = 0;
   bit    pin_hs = 1'b0, pin_hb = 1'b0, pin_rdy = 1'b0, pin_pe = 1'b0;

   // Line phase from position: sync at 4..7, blank ends at 17 (19 when extended).
   function automatic int exp_state(input int c, input bit e);
      if (c < 4) return 0;
      if (c < 8) return 1;
      if (c < (e ? 19 : 17)) return 2;
      return 3;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: model every cycle, literal checkpoints when posted.
   always @(negedge clk) begin
      int es;
      if (model_on) begin
         es = exp_state(m_count, m_ext);
         chk("hcount",    int'(bus.hcount),    m_count);
         chk("hstate",    int'(bus.hstate),    es);
         chk("hsync",     int'(bus.hsync),     int'(es == 1));
         chk("hblank",    int'(bus.hblank),    int'(es != 3));
         chk("rdy",       int'(bus.rdy),       int'(!m_halt));
         chk("phase_err", int'(bus.phase_err), int'(m_err));
      end
      if (pin_valid) begin
         chk({pin_name, ".hcount"},    int'(bus.hcount),    pin_hc);
         chk({pin_name, ".hstate"},    int'(bus.hstate),    pin_hst);
         chk({pin_name, ".hsync"},     int'(bus.hsync),     int'(pin_hs));
         chk({pin_name, ".hblank"},    int'(bus.hblank),    int'(pin_hb));
         chk({pin_name, ".rdy"},       int'(bus.rdy),       int'(pin_rdy));
         chk({pin_name, ".phase_err"}, int'(bus.phase_err), int'(pin_pe));
      end
   end

   task automatic model_update(input bit p1, p2, w, rs, hm, rr);
      bit adv, reff, wrp;
      if (rr) begin
         m_count = 0; m_ext = 0; m_latch = 0; m_halt = 0;
         m_err = 0; m_pend = 0; m_pphi2 = 0;
      end else begin
         adv  = p2 && !m_pphi2 && !p1;
         reff = m_pend || rs;
         wrp  = adv && (reff || m_count >= 56);
         if (p1 && p2) m_err = 1;
         if (adv) begin
            m_count = wrp ? 0 : m_count + 1;
            m_pend  = 0;
            if (m_count == 17) m_ext = m_latch;
         end else begin
            m_pend = reff;
         end
         if (w) m_halt = 1;
         else if (wrp) m_halt = 0;
         if (hm) m_latch = 1;
         else if (wrp) m_latch = 0;
         m_pphi2 = p2;
      end
   endtask

   // One clk cycle of the 4-phase biphase pattern with optional strobes.
   task automatic step(input bit w = 0, rs = 0, hm = 0, ov = 0, rr = 0, p2 = 0);
      bit p1v, p2v;
      p1v = ov || (ph == 0 && !p2);
      p2v = ov || p2 || (ph == 2);
      bus.phi1  = p1v;
      bus.phi2  = p2v;
      bus.wsync = w;
      bus.rsync = rs;
      bus.hmove = hm;
      r         = rr;
      @(posedge clk);
      model_update(p1v, p2v, w, rs, hm, rr);
      if (rr) model_on = 1'b1;
      ph = rr ? 0 : (ph + 1) % 4;
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic to_count(input int c);
      for (int i = 0; i < 500; i++) begin
         step();
         if (m_count == c) return;
      end
      $display("FAIL to_count: got %0d expected %0d", m_count, c);
      $fatal(1, "cycle budget expired");
   endtask

   task automatic to_wrap_cycle();
      for (int i = 0; i < 500; i++) begin
         if (m_count == 56 && ph == 2 && !m_pphi2) return;
         step();
      end
      $display("FAIL to_wrap_cycle: got %0d expected %0d", m_count, 56);
      $fatal(1, "cycle budget expired");
   endtask

   task automatic pin(input string nm, input int hc, hst, input bit hs, hb, rd, pe);
      pin_name = nm; pin_hc = hc; pin_hst = hst;
      pin_hs = hs; pin_hb = hb; pin_rdy = rd; pin_pe = pe;
      pin_valid = 1'b1;
      @(negedge clk);
      #1;
      pin_valid = 1'b0;
   endtask

   initial begin
      bus.phi1 = 0; bus.phi2 = 0; bus.wsync = 0; bus.rsync = 0; bus.hmove = 0;
      step(.rr(1));
      step(.rr(1));
      pin("reset", 0, 0, 0, 1, 1, 0);

      // Plain line: one advance per 4 clk, 228 clk per line.
      run(16);  pin("hs_start", 4, 1, 1, 1, 1, 0);
      run(12);  pin("hs_end",   7, 1, 1, 1, 1, 0);
      run(4);   pin("hb_late",  8, 2, 0, 1, 1, 0);
      run(32);  pin("c16",     16, 2, 0, 1, 1, 0);
      run(4);   pin("c17",     17, 3, 0, 0, 1, 0);
      run(156); pin("c56",     56, 3, 0, 0, 1, 0);
      run(4);   pin("wrap228",  0, 0, 0, 1, 1, 0);

      // Extended blank, then a normal line.
      run(40);
      step(.hm(1));
      run(31);  pin("hm_c18",  18, 2, 0, 1, 1, 0);
      run(4);   pin("hm_c19",  19, 3, 0, 0, 1, 0);
      run(152); pin("hm_wrap",  0, 0, 0, 1, 1, 0);
      run(64);  pin("nh_c16",  16, 2, 0, 1, 1, 0);
      run(4);   pin("nh_c17",  17, 3, 0, 0, 1, 0);

      // WSYNC halt, repeated strobe, release at wrap.
      to_count(30);
      step(.w(1));  pin("ws_c30", 30, 3, 0, 0, 0, 0);
      to_count(40);
      step(.w(1));
      to_count(56); pin("ws_c56", 56, 3, 0, 0, 0, 0);
      to_count(0);  pin("ws_rel",  0, 0, 0, 1, 1, 0);

      // WSYNC coincident with the wrap advance halts the whole next line.
      to_wrap_cycle();
      step(.w(1));  pin("wsw_c0",  0, 0, 0, 1, 0, 0);
      to_count(30); pin("wsw_c30", 30, 3, 0, 0, 0, 0);
      to_count(0);  pin("wsw_rel",  0, 0, 0, 1, 1, 0);

      // HMOVE coincident with the wrap extends the new line.
      to_wrap_cycle();
      step(.hm(1));
      to_count(18); pin("hmw_c18", 18, 2, 0, 1, 1, 0);
      to_count(19); pin("hmw_c19", 19, 3, 0, 0, 1, 0);

      // RSYNC mid-line releases a halt; pending across non-advance cycles.
      to_count(35);
      step(.w(1));
      to_count(40);
      step(.rs(1)); pin("rs_c40", 40, 3, 0, 0, 0, 0);
      to_count(0);  pin("rs_c0",   0, 0, 0, 1, 1, 0);

      // RSYNC in the same cycle as the advance.
      to_count(5);
      repeat (4) if (ph != 2) step();
      step(.rs(1)); pin("rsa_c0",  0, 0, 0, 1, 1, 0);

      // Biphase overlap: no advance that cycle, sticky error.
      to_count(12);
      step(.ov(1)); pin("ov_c12", 12, 2, 0, 1, 1, 1);
      to_count(14);
      repeat (6) step(.p2(1));
      to_count(20); pin("ov_c20", 20, 3, 0, 0, 1, 1);

      // Reset mid-line with halt and hmove latched.
      to_count(45);
      step(.hm(1));
      step(.w(1));
      to_count(50);
      step(.rr(1)); pin("rst_mid", 0, 0, 0, 1, 1, 0);
      run(68);      pin("rst_c17", 17, 3, 0, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
